// File: rtl/compute_sequencer_if.sv
// Sequencer bus: job handshake, A/B memory read addresses, MAC strobes and
// the result handshake. Master is the sequencer; slave is the datapath/memory side.
interface compute_sequencer_if #(
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8
);
  localparam int K_BITS      = $clog2(MAXK + 1);
  localparam int A_ADDR_BITS = $clog2(M * MAXK);
  localparam int B_ADDR_BITS = $clog2(MAXK * N);

  logic                   matrices_loaded;
  logic [K_BITS-1:0]      K;
  logic [A_ADDR_BITS-1:0] A_read_addr;
  logic [B_ADDR_BITS-1:0] B_read_addr;
  logic                   mac_en;
  logic                   mac_first;
  logic                   result_valid;
  logic                   result_ready;
  logic                   compute_finished;

  modport master (
    input  matrices_loaded, K, result_ready,
    output A_read_addr, B_read_addr, mac_en, mac_first, result_valid, compute_finished
  );

  modport slave (
    output matrices_loaded, K, result_ready,
    input  A_read_addr, B_read_addr, mac_en, mac_first, result_valid, compute_finished
  );
endinterface

// File: rtl/compute_sequencer.sv
// Matrix-multiply sequencer: walks C[i][j] in row-major order, issuing the
// K-long dot-product reads for each element, then holds the finished
// accumulator until downstream takes it.
module compute_sequencer #(
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8
) (
  input logic clk,
  input logic reset,
  compute_sequencer_if.master bus
);
  localparam int K_BITS      = $clog2(MAXK + 1);
  localparam int A_ADDR_BITS = $clog2(M * MAXK);
  localparam int B_ADDR_BITS = $clog2(MAXK * N);
  localparam int I_BITS      = (M > 1) ? $clog2(M) : 1;
  localparam int J_BITS      = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, DONE, UNLOAD} state_t;

  state_t state, state_nxt;

  logic [K_BITS-1:0]      k_len, k;
  logic [I_BITS-1:0]      i;
  logic [J_BITS-1:0]      j;
  logic [A_ADDR_BITS-1:0] a_base, a_hold, a_addr_c;
  logic [B_ADDR_BITS-1:0] b_off, b_hold, b_addr_c;
  logic                   mac_en_q, mac_first_q;
  logic                   k_last, ij_last;

  // Running bases replace i*k_len and k*N; carries past the width are dropped.
  assign a_addr_c = a_base + A_ADDR_BITS'(k);
  assign b_addr_c = b_off + B_ADDR_BITS'(j);
  assign k_last   = (k == k_len - K_BITS'(1));
  assign ij_last  = (i == I_BITS'(M - 1)) && (j == J_BITS'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; K is checked directly since k_len loads on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.matrices_loaded) state_nxt = (bus.K != '0) ? ISSUE : DONE;
      ISSUE:   if (k_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (bus.result_ready) state_nxt = ij_last ? DONE : ISSUE;
      DONE:    state_nxt = UNLOAD;
      UNLOAD:  if (!bus.matrices_loaded) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index counters, address bases and held addresses; mac strobes trail ISSUE by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_len       <= '0;
      k           <= '0;
      i           <= '0;
      j           <= '0;
      a_base      <= '0;
      b_off       <= '0;
      a_hold      <= '0;
      b_hold      <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      mac_en_q    <= (state == ISSUE);
      mac_first_q <= (state == ISSUE) && (k == '0);
      case (state)
        IDLE: if (bus.matrices_loaded) begin
          k_len  <= bus.K;
          k      <= '0;
          i      <= '0;
          j      <= '0;
          a_base <= '0;
          b_off  <= '0;
        end
        ISSUE: begin
          a_hold <= a_addr_c;
          b_hold <= b_addr_c;
          if (k_last) begin
            k     <= '0;
            b_off <= '0;
          end else begin
            k     <= k + K_BITS'(1);
            b_off <= b_off + B_ADDR_BITS'(N);
          end
        end
        OUT: if (bus.result_ready && !ij_last) begin
          if (j == J_BITS'(N - 1)) begin
            j      <= '0;
            i      <= i + I_BITS'(1);
            a_base <= a_base + A_ADDR_BITS'(k_len);
          end else begin
            j <= j + J_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: live address during ISSUE, otherwise the last issued one.
  always_comb begin
    bus.A_read_addr      = (state == ISSUE) ? a_addr_c : a_hold;
    bus.B_read_addr      = (state == ISSUE) ? b_addr_c : b_hold;
    bus.mac_en           = mac_en_q;
    bus.mac_first        = mac_first_q;
    bus.result_valid     = (state == OUT);
    bus.compute_finished = (state == DONE);
  end
endmodule

// File: tb/tb_compute_sequencer.sv
// Bench for compute_sequencer: a small 2x3 instance checked against a
// scoreboard of expected read addresses and dot products, plus a default
// 7x9 instance for the K=1 sweep.
module tb_compute_sequencer;
  localparam int M = 2, N = 3, MAXK = 8;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  compute_sequencer_if #(.M(M), .N(N), .MAXK(MAXK)) bus ();
  compute_sequencer_if bus_big ();

  compute_sequencer #(.M(M), .N(N), .MAXK(MAXK)) u_dut (.clk(gclk), .reset(grst_n), .bus(bus));
  compute_sequencer u_big (.clk(gclk), .reset(grst_n), .bus(bus_big));

  int vectors = 0, miscompares = 0;
  int A_mem [16];
  int B_mem [24];
  int q_a [$], q_b [$], q_f [$], q_c [$];
  int acc = 0, fin_cnt = 0, res_cnt = 0, res2 = 0;
  logic [3:0] pa = '0;
  logic [4:0] pb = '0;
  logic [5:0] pa2 = '0;
  logic [6:0] pb2 = '0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // Fresh memory contents plus the expected reads and results for one job.
  task automatic push_exp(input int kk);
    int c;
    for (int a = 0; a < 16; a++) A_mem[a] = int'($urandom_range(0, 15));
    for (int b = 0; b < 24; b++) B_mem[b] = int'($urandom_range(0, 15));
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < kk; k++) begin
          q_a.push_back(i * kk + k);
          q_b.push_back(k * N + j);
          q_f.push_back(int'(k == 0));
          c += A_mem[i * kk + k] * B_mem[k * N + j];
        end
        if (kk > 0) q_c.push_back(c);
      end
  endtask

  // Small-instance monitor: the address seen one cycle before mac_en is what the memory returns.
  always @(negedge gclk) begin
    if (grst_n) begin
      if (bus.mac_en) begin
        if (q_a.size() == 0) chk("extra_mac", 1, 0);
        else begin
          chk("a_addr", int'(pa), q_a.pop_front());
          chk("b_addr", int'(pb), q_b.pop_front());
          chk("mac_first", int'(bus.mac_first), q_f.pop_front());
        end
        acc <= bus.mac_first ? A_mem[pa] * B_mem[pb] : acc + A_mem[pa] * B_mem[pb];
      end
      if (bus.result_valid) begin
        chk("out_no_mac", int'(bus.mac_en), 0);
        chk("out_a_hold", int'(bus.A_read_addr), int'(pa));
        chk("out_b_hold", int'(bus.B_read_addr), int'(pb));
        if (bus.result_ready) begin
          if (q_c.size() == 0) chk("extra_result", 1, 0);
          else chk("result", acc, q_c.pop_front());
          res_cnt <= res_cnt + 1;
        end
      end
      if (bus.compute_finished) fin_cnt <= fin_cnt + 1;
    end
    pa <= bus.A_read_addr;
    pb <= bus.B_read_addr;
  end

  // Default-size monitor for the K=1 sweep: A addr is i, B addr is j.
  always @(negedge gclk) begin
    if (grst_n) begin
      if (bus_big.mac_en) begin
        chk("k1_first", int'(bus_big.mac_first), 1);
        chk("k1_b_is_j", int'(pb2), res2 % 9);
        chk("k1_a_is_i", int'(pa2), res2 / 9);
      end
      if (bus_big.result_valid && bus_big.result_ready) res2 <= res2 + 1;
    end
    pa2 <= bus_big.A_read_addr;
    pb2 <= bus_big.B_read_addr;
  end

  task automatic wait_done(input int kk, input bit stall, input bit drop, input int fc0, input int rc0);
    int w;
    if (stall) begin
      w = 0;
      while (!bus.result_valid && w < 200) begin step(); w++; end
      chk("stall_valid_seen", int'(bus.result_valid), 1);
      for (int s = 0; s < 5; s++) begin
        step();
        chk("stall_valid_held", int'(bus.result_valid), 1);
      end
      bus.result_ready = 1'b1;
    end
    w = 0;
    while (!bus.compute_finished && w < 2000) begin step(); w++; end
    chk("finished_seen", int'(bus.compute_finished), 1);
    if (kk == 0) chk("k0_fin_latency", w, 1);
    if (drop) bus.matrices_loaded = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("post_fin_mac", int'(bus.mac_en), 0);
      chk("post_fin_valid", int'(bus.result_valid), 0);
      chk("post_fin_pulse", int'(bus.compute_finished), 0);
    end
    chk("fin_pulses", fin_cnt - fc0, 1);
    chk("result_count", res_cnt - rc0, (kk > 0) ? M * N : 0);
    chk("queue_drained", q_a.size() + q_c.size(), 0);
  endtask

  task automatic run_job(input int kk, input bit stall, input bit drop);
    int fc0, rc0;
    push_exp(kk);
    fc0 = fin_cnt;
    rc0 = res_cnt;
    bus.result_ready    = !stall;
    bus.K               = 4'(kk);
    bus.matrices_loaded = 1'b1;
    if (kk > 0) begin
      step();
      bus.K = 4'(kk + 5);   // must be ignored mid-job
    end
    wait_done(kk, stall, drop, fc0, rc0);
  endtask

  initial begin
    int fc0, rc0, w;
    bus.matrices_loaded     = 1'b0;
    bus.K                   = '0;
    bus.result_ready        = 1'b1;
    bus_big.matrices_loaded = 1'b0;
    bus_big.K               = '0;
    bus_big.result_ready    = 1'b1;
    step();
    step();
    chk("rst_a_addr", int'(bus.A_read_addr), 0);
    chk("rst_b_addr", int'(bus.B_read_addr), 0);
    chk("rst_mac_en", int'(bus.mac_en), 0);
    chk("rst_mac_first", int'(bus.mac_first), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_fin", int'(bus.compute_finished), 0);
    grst_n = 1'b1;
    step();

    run_job(2, 1'b0, 1'b1);   // basic 2x3, K=2
    run_job(2, 1'b1, 1'b1);   // first result stalled 5 cycles
    run_job(0, 1'b0, 1'b1);   // empty job
    run_job(5, 1'b0, 1'b1);   // longer dot products

    // Reset during the second ISSUE cycle with matrices_loaded held high.
    bus.result_ready    = 1'b1;
    bus.K               = 4'd2;
    bus.matrices_loaded = 1'b1;
    step();
    step();
    grst_n = 1'b0;
    #1;
    chk("abort_a_addr", int'(bus.A_read_addr), 0);
    chk("abort_b_addr", int'(bus.B_read_addr), 0);
    chk("abort_mac_en", int'(bus.mac_en), 0);
    chk("abort_mac_first", int'(bus.mac_first), 0);
    chk("abort_valid", int'(bus.result_valid), 0);
    chk("abort_fin", int'(bus.compute_finished), 0);
    push_exp(2);
    fc0 = fin_cnt;
    rc0 = res_cnt;
    step();
    step();
    grst_n = 1'b1;
    wait_done(2, 1'b0, 1'b1, fc0, rc0);

    // matrices_loaded stays high past the job; nothing may restart until it drops.
    run_job(2, 1'b0, 1'b0);
    bus.matrices_loaded = 1'b0;
    step();
    run_job(3, 1'b0, 1'b1);

    // Default 7x9 instance, K=1.
    bus_big.K               = 4'd1;
    bus_big.matrices_loaded = 1'b1;
    w = 0;
    while (!bus_big.compute_finished && w < 1000) begin step(); w++; end
    chk("k1_finished_seen", int'(bus_big.compute_finished), 1);
    bus_big.matrices_loaded = 1'b0;
    step();
    step();
    chk("k1_results", res2, 63);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
